// File: rtl/rs232_tx_ctrl.sv
// RS-232 transmit sequencer: round-robin grant between two requesters, byte capture,
// and busy window / bit-slot index generation at the configured baud rate.
module rs232_tx_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk_ref,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic [7:0] i_dat0,
  input  logic [7:0] i_dat1,
  output logic [1:0] o_ack,
  output logic       o_done,
  output logic       o_rs232_busy,
  output logic [3:0] o_ctrl_cnt,
  output logic [7:0] o_tx_dat
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_reg;
  logic [BW-1:0] baud_reg;
  logic [3:0]    cnt_reg;
  logic          busy_reg;
  logic [7:0]    dat_reg;
  logic [1:0]    ack_reg;
  logic          done_reg;
  logic          last_reg;   // requester served by the most recent completed frame
  logic          gnt_reg;    // requester owning the frame in progress
  logic          gnt_next;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_next = i_req[1];
    if (i_req == 2'b11) gnt_next = ~last_reg;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      dat_reg   <= '0;
      ack_reg   <= '0;
      done_reg  <= 1'b0;
      last_reg  <= 1'b1;
      gnt_reg   <= 1'b0;
    end else begin
      ack_reg  <= '0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_req != 2'b00) begin
            state_reg <= SEND;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            baud_reg  <= '0;
            gnt_reg   <= gnt_next;
            dat_reg   <= gnt_next ? i_dat1 : i_dat0;
            ack_reg   <= gnt_next ? 2'b10 : 2'b01;
          end
        end
        SEND: begin
          if (baud_reg == BAUD_LAST) begin
            baud_reg <= '0;
            if (cnt_reg == 4'd9) begin
              // Always drop to IDLE for at least one cycle so the datapath sees a busy edge.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              cnt_reg   <= '0;
              done_reg  <= 1'b1;
              last_reg  <= gnt_reg;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end else begin
            baud_reg <= baud_reg + BW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_ack        = ack_reg;
  assign o_done       = done_reg;
  assign o_rs232_busy = busy_reg;
  assign o_ctrl_cnt   = cnt_reg;
  assign o_tx_dat     = dat_reg;

endmodule

// File: tb/tb_rs232_tx_ctrl.sv
// Self-checking bench for rs232_tx_ctrl: table-driven frames plus hand-written
// sequences for data change mid-frame, stray request pulses and async reset.
module tb_rs232_tx_ctrl;

  localparam int BD = 10;

  logic       clk_ref = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] i_req   = 2'b00;
  logic [7:0] i_dat0  = 8'h00;
  logic [7:0] i_dat1  = 8'h00;
  logic [1:0] o_ack;
  logic       o_done;
  logic       o_rs232_busy;
  logic [3:0] o_ctrl_cnt;
  logic [7:0] o_tx_dat;

  int checks   = 0;
  int failures = 0;

  rs232_tx_ctrl #(.CLK_FREQ(100), .BAUD_RATE(10)) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_dat0      (i_dat0),
    .i_dat1      (i_dat1),
    .o_ack       (o_ack),
    .o_done      (o_done),
    .o_rs232_busy(o_rs232_busy),
    .o_ctrl_cnt  (o_ctrl_cnt),
    .o_tx_dat    (o_tx_dat)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    logic       rst_before;
    logic       hold;
    logic       chk_gap;
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_ack;
    logic [7:0] exp_dat;
    logic [9:0] exp_line;  // bit i = expected TX line level in slot i
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Line level the datapath would drive from the busy/slot/byte outputs.
  function automatic logic line_of(input logic busy, input logic [3:0] cnt, input logic [7:0] dat);
    if (!busy) return 1'b1;
    if (cnt == 4'd0) return 1'b0;
    if (cnt >= 4'd9) return 1'b1;
    return dat[3'(cnt - 4'd1)];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 2'b00;
    repeat (3) @(negedge clk_ref);
    rst_n = 1'b1;
  endtask

  task automatic wait_slot(input int c, input string nm);
    int n = 0;
    while (!(o_rs232_busy && o_ctrl_cnt == 4'(c)) && n < 300) begin
      n++;
      @(negedge clk_ref);
    end
    chk(nm, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_ack(output int idle);
    idle = 0;
    @(negedge clk_ref);
    while (o_ack == 2'b00 && idle < 50) begin
      idle++;
      @(negedge clk_ref);
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int idle;
    int k = 0;
    int bad_cnt = 0;
    int bad_line = 0;
    int bad_pulse = 0;
    i_dat0 = v.d0;
    i_dat1 = v.d1;
    i_req  = v.req;
    wait_ack(idle);
    chk($sformatf("v%0d_ack", idx), 32'(o_ack), 32'(v.exp_ack));
    chk($sformatf("v%0d_dat", idx), 32'(o_tx_dat), 32'(v.exp_dat));
    chk($sformatf("v%0d_busy_rise", idx), 32'(o_rs232_busy), 32'd1);
    if (v.chk_gap) chk($sformatf("v%0d_gap", idx), 32'(idle), 32'd0);
    if (!v.hold) i_req = 2'b00;
    while (o_rs232_busy && k < 200) begin
      if (o_ctrl_cnt != 4'(k / BD)) bad_cnt++;
      if (line_of(o_rs232_busy, o_ctrl_cnt, o_tx_dat) != v.exp_line[k / BD]) bad_line++;
      if ((k > 0 && o_ack != 2'b00) || o_done) bad_pulse++;
      k++;
      @(negedge clk_ref);
    end
    chk($sformatf("v%0d_busy_width", idx), 32'(k), 32'(10 * BD));
    chk($sformatf("v%0d_cnt_seq_errs", idx), 32'(bad_cnt), 32'd0);
    chk($sformatf("v%0d_line_errs", idx), 32'(bad_line), 32'd0);
    chk($sformatf("v%0d_stray_pulses", idx), 32'(bad_pulse), 32'd0);
    chk($sformatf("v%0d_done", idx), 32'(o_done), 32'd1);
  endtask

  initial begin
    int bad;
    int idle;
    int n;

    //          rst  hold gap  req    d0     d1     ack    dat    line (slot9..slot0)
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b01, 8'hA5, 8'h00, 2'b01, 8'hA5, 10'b11_0100_1010};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 10'b10_0010_0010};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2'b11, 8'h11, 8'h22, 2'b10, 8'h22, 10'b10_0100_0100};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 2'b01, 8'h11, 10'b10_0010_0010};

    // Reset state and a long quiet idle period.
    do_reset();
    @(negedge clk_ref);
    chk("rst_busy", 32'(o_rs232_busy), 32'd0);
    chk("rst_cnt", 32'(o_ctrl_cnt), 32'd0);
    chk("rst_dat", 32'(o_tx_dat), 32'h00);
    chk("rst_ack", 32'(o_ack), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_rs232_busy || o_ctrl_cnt != 4'd0 || o_tx_dat != 8'h00 || o_ack != 2'b00 || o_done) bad++;
      @(negedge clk_ref);
    end
    chk("idle_quiet_errs", 32'(bad), 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].rst_before) do_reset();
      run_frame(i, vecs[i]);
    end

    // Data change mid-frame is ignored; a one-cycle request pulse in SEND is dropped.
    i_dat0 = 8'h3C;
    i_req  = 2'b01;
    wait_ack(idle);
    chk("hold_ack", 32'(o_ack), 32'b01);
    i_req = 2'b00;
    wait_slot(4, "hold_reach_cnt4");
    i_dat0 = 8'hFF;
    i_dat1 = 8'h99;
    i_req  = 2'b10;
    @(negedge clk_ref);
    i_req = 2'b00;
    bad = 0;
    n = 0;
    while (o_rs232_busy && n < 200) begin
      if (o_tx_dat != 8'h3C) bad++;
      n++;
      @(negedge clk_ref);
    end
    chk("hold_dat_errs", 32'(bad), 32'd0);
    chk("hold_dat_at_end", 32'(o_tx_dat), 32'h3C);
    chk("hold_done", 32'(o_done), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_ref);
      if (o_ack != 2'b00 || o_rs232_busy) bad++;
    end
    chk("pulse_no_frame_errs", 32'(bad), 32'd0);

    // Asynchronous reset mid-frame, then a fresh grant to requester 1.
    i_dat0 = 8'h5A;
    i_req  = 2'b01;
    wait_ack(idle);
    chk("abort_ack", 32'(o_ack), 32'b01);
    i_req = 2'b00;
    wait_slot(5, "abort_reach_cnt5");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(o_rs232_busy), 32'd0);
    chk("abort_cnt", 32'(o_ctrl_cnt), 32'd0);
    chk("abort_dat", 32'(o_tx_dat), 32'h00);
    chk("abort_done", 32'(o_done), 32'd0);
    i_req  = 2'b10;
    i_dat1 = 8'h77;
    bad = 0;
    repeat (2) begin
      @(negedge clk_ref);
      if (o_done || o_rs232_busy) bad++;
    end
    rst_n = 1'b1;
    wait_ack(idle);
    chk("abort_held_errs", 32'(bad), 32'd0);
    chk("after_rst_ack", 32'(o_ack), 32'b10);
    chk("after_rst_dat", 32'(o_tx_dat), 32'h77);
    i_req = 2'b00;
    n = 0;
    while (o_rs232_busy && n < 200) begin
      n++;
      @(negedge clk_ref);
    end
    chk("after_rst_width", 32'(n), 32'(10 * BD));
    chk("after_rst_done", 32'(o_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
